// File: rtl/sindoku_check_seq.sv
// Sudoku board checker: scans all 81 cells through a board read port shared with a
// display reader, counting mismatches and blanks and recording the first mismatch.
module sindoku_check_seq (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       disp_req,
  input  logic [6:0] disp_addr,
  output logic [6:0] mem_addr,
  input  logic [4:0] puzzle_q,
  input  logic [4:0] solu_q,
  output logic       disp_valid,
  output logic       busy,
  output logic       done,
  output logic       correct,
  output logic [6:0] err_count,
  output logic [6:0] blank_count,
  output logic [3:0] first_err_row,
  output logic [3:0] first_err_col,
  output logic       q_Idle,
  output logic       q_Scan,
  output logic       q_Drain,
  output logic       q_Done
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned CELL_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(8);
  localparam logic [IDX_W-1:0] NO_ERR   = IDX_W'(15);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SCAN  = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t           state, state_nxt;
  logic             scan_issue, start_scan;
  logic [IDX_W-1:0] row, col;
  logic             tag_v;
  logic [IDX_W-1:0] tag_row, tag_col;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and scan issue control
  always_comb begin
    state_nxt  = state;
    scan_issue = 1'b0;
    start_scan = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt  = SCAN;
          start_scan = 1'b1;
        end
      end
      SCAN: begin
        if (!disp_req) begin
          scan_issue = 1'b1;
          if (row == LAST_IDX && col == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    if (Ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared port address: display always wins, idle port parks at 0
  always_comb begin
    mem_addr = '0;
    if (disp_req)           mem_addr = disp_addr;
    else if (state == SCAN) mem_addr = ADDR_W'(row) * ADDR_W'(9) + ADDR_W'(col);
  end

  // Scan position, return tag and result accumulation
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row           <= '0;
      col           <= '0;
      tag_v         <= 1'b0;
      tag_row       <= '0;
      tag_col       <= '0;
      disp_valid    <= 1'b0;
      err_count     <= '0;
      blank_count   <= '0;
      first_err_row <= NO_ERR;
      first_err_col <= NO_ERR;
    end else begin
      disp_valid <= disp_req;
      tag_v      <= scan_issue;
      if (start_scan) begin
        row <= '0;
        col <= '0;
      end else if (scan_issue) begin
        tag_row <= row;
        tag_col <= col;
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + IDX_W'(1);
        end else begin
          col <= col + IDX_W'(1);
        end
      end

      if (start_scan) begin
        err_count     <= '0;
        blank_count   <= '0;
        first_err_row <= NO_ERR;
        first_err_col <= NO_ERR;
      end else if (tag_v && !disp_valid) begin
        if (puzzle_q != solu_q) begin
          err_count <= err_count + CNT_W'(1);
          if (err_count == '0) begin
            first_err_row <= tag_row;
            first_err_col <= tag_col;
          end
        end
        if (puzzle_q == CELL_W'(0)) blank_count <= blank_count + CNT_W'(1);
      end
    end
  end

  assign q_Idle  = (state == IDLE);
  assign q_Scan  = (state == SCAN);
  assign q_Drain = (state == DRAIN);
  assign q_Done  = (state == DONE);
  assign busy    = q_Scan | q_Drain;
  assign done    = q_Done;
  assign correct = q_Done && (err_count == '0);

endmodule

// File: tb/tb_sindoku_check_seq.sv
// Bench for sindoku_check_seq: board memory model, directed scenarios, and a
// scoreboard that checks every completed board check when done rises.
module tb_sindoku_check_seq;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack, disp_req;
  logic [6:0] disp_addr, mem_addr;
  logic [4:0] puzzle_q, solu_q;
  logic       disp_valid, busy, done, correct;
  logic [6:0] err_count, blank_count;
  logic [3:0] first_err_row, first_err_col;
  logic       q_Idle, q_Scan, q_Drain, q_Done;

  sindoku_check_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .disp_req(disp_req), .disp_addr(disp_addr), .mem_addr(mem_addr),
    .puzzle_q(puzzle_q), .solu_q(solu_q), .disp_valid(disp_valid),
    .busy(busy), .done(done), .correct(correct),
    .err_count(err_count), .blank_count(blank_count),
    .first_err_row(first_err_row), .first_err_col(first_err_col),
    .q_Idle(q_Idle), .q_Scan(q_Scan), .q_Drain(q_Drain), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Board memory: registered read, one cycle after mem_addr
  logic [4:0] puz [81];
  logic [4:0] sol [81];
  always @(posedge Clk) begin
    puzzle_q <= (mem_addr < 7'd81) ? puz[mem_addr] : 5'd0;
    solu_q   <= (mem_addr < 7'd81) ? sol[mem_addr] : 5'd0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int err; int blank; int row; int col; int corr; int cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;
  logic done_q = 1'b0;

  // Monitor: compare each completed check against the queued expectation
  always @(negedge Clk) begin
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_err_count",   int'(err_count),     e.err);
        chk("sb_blank_count", int'(blank_count),   e.blank);
        chk("sb_first_row",   int'(first_err_row), e.row);
        chk("sb_first_col",   int'(first_err_col), e.col);
        chk("sb_correct",     int'(correct),       e.corr);
        chk("sb_done_cycle",  cyc,                 e.cyc);
      end
    end
    done_q = done;
  end

  // Valid sudoku solution; puzzle starts as an exact copy
  task automatic load_match();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        sol[r*9+c] = 5'(((r*3 + r/3 + c) % 9) + 1);
        puz[r*9+c] = sol[r*9+c];
      end
  endtask

  task automatic push_exp(input int er, input int bl, input int rw, input int cl,
                          input int co, input int dcyc);
    exp_t x;
    x.err = er; x.blank = bl; x.row = rw; x.col = cl; x.corr = co; x.cyc = dcyc;
    sb_q.push_back(x);
  endtask

  // Start sampled at the next edge; returns the cycle count at that edge
  task automatic pulse_start(output int sc);
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1;
    sc = cyc;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_ack();
    @(negedge Clk) Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
  endtask

  // done rises 82 edges after the Start-sample edge (83 edges inclusive), plus stalls
  localparam int LAT = 82;
  localparam int NO  = 15;

  initial begin
    int sc;
    int n;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; disp_req = 1'b0; disp_addr = '0;
    load_match();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_q_idle",  q_Idle, 1);
    chk("rst_q_other", int'({q_Scan, q_Drain, q_Done}), 0);
    chk("rst_err",     err_count, 0);
    chk("rst_blank",   blank_count, 0);
    chk("rst_frow",    first_err_row, NO);
    chk("rst_fcol",    first_err_col, NO);
    chk("rst_flags",   int'({done, busy, correct, disp_valid}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    Reset = 1'b0;

    // Matching board, no display traffic
    pulse_start(sc);
    push_exp(0, 0, NO, NO, 1, sc + LAT);
    chk("match_busy", busy, 1);
    wait_done("match");
    pulse_ack();

    // Blanks at (0,0), (4,4), (8,8)
    puz[0] = 5'd0; puz[40] = 5'd0; puz[80] = 5'd0;
    pulse_start(sc);
    push_exp(3, 3, 0, 0, 0, sc + LAT);
    wait_done("blanks");
    pulse_ack();

    // Single wrong value at (5,7) with the display stealing every other cycle
    load_match();
    puz[52] = 5'((int'(sol[52]) % 9) + 1);
    pulse_start(sc);
    push_exp(1, 0, 5, 7, 0, sc + LAT + 80);
    n = 0;
    while (!done && n < 400) begin
      disp_req  = n[0];
      disp_addr = 7'(n % 81);
      @(posedge Clk); #1;
      n++;
    end
    disp_req = 1'b0;
    chk("stall_done_seen", done, 1);
    pulse_ack();

    // Start with the display holding the port for 10 cycles
    load_match();
    @(negedge Clk);
    Start = 1'b1; disp_req = 1'b1; disp_addr = 7'd42;
    chk("hold_dv_before", disp_valid, 0);
    @(posedge Clk); #1;
    sc = cyc;
    Start = 1'b0;
    push_exp(0, 0, NO, NO, 1, sc + LAT + 9);
    chk("hold_dv_after", disp_valid, 1);
    for (int i = 0; i < 9; i++) begin
      chk("hold_mem_addr", mem_addr, 42);
      chk("hold_q_scan", q_Scan, 1);
      @(posedge Clk); #1;
    end
    disp_req = 1'b0;
    #1;
    chk("resume_addr_00", mem_addr, 0);
    chk("resume_dv_lag", disp_valid, 1);
    @(posedge Clk); #1;
    chk("resume_addr_01", mem_addr, 1);
    chk("resume_dv_clear", disp_valid, 0);
    wait_done("hold");
    pulse_ack();

    // Reset while cell (3,2) is about to issue, then a fresh full check
    puz[0] = 5'd0; puz[40] = 5'd0; puz[80] = 5'd0;
    pulse_start(sc);
    n = 0;
    while (mem_addr != 7'd29 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("midscan_reached", mem_addr, 29);
    chk("midscan_err_pre", err_count, 1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("midrst_q_idle", q_Idle, 1);
    chk("midrst_err",   err_count, 0);
    chk("midrst_blank", blank_count, 0);
    chk("midrst_frow",  first_err_row, NO);
    chk("midrst_fcol",  first_err_col, NO);
    chk("midrst_busy",  busy, 0);
    pulse_start(sc);
    push_exp(3, 3, 0, 0, 0, sc + LAT);
    wait_done("after_reset");
    pulse_ack();

    // Ack during SCAN and Start during DONE are ignored
    load_match();
    puz[52] = 5'd0;
    pulse_start(sc);
    push_exp(1, 1, 5, 7, 0, sc + LAT);
    repeat (5) @(posedge Clk);
    pulse_ack();
    chk("ack_in_scan_ignored", q_Scan, 1);
    wait_done("ignore");
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("start_in_done_ignored", q_Done, 1);
    chk("done_hold_err", err_count, 1);
    pulse_ack();
    chk("ack_to_idle", q_Idle, 1);
    chk("idle_done_low", done, 0);
    chk("idle_correct_low", correct, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("idle_hold_err",   err_count, 1);
    chk("idle_hold_blank", blank_count, 1);
    chk("idle_hold_frow",  first_err_row, 5);
    chk("idle_hold_fcol",  first_err_col, 7);
    chk("idle_mem_addr",   mem_addr, 0);

    repeat (2) @(posedge Clk);
    chk("sb_queue_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sindoku_check_seq.md
SINDOKU_CHECK_SEQ -- requirements
Module: sindoku_check_seq

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- Clk  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a full-board check; sampled only in IDLE.
- Ack  in  1  acknowledge result; sampled only in DONE.
- disp_req  in  1  display read request for the shared board port.
- disp_addr  in  7  display cell address, 0..80, row*9+col.
- mem_addr  out  7  shared board read address, combinational mux.
- puzzle_q  in  5  puzzle cell value, valid one cycle after mem_addr.
- solu_q  in  5  solution cell value, valid one cycle after mem_addr.
- disp_valid  out  1  puzzle_q/solu_q belong to the display this cycle.
- busy  out  1  high in SCAN or DRAIN.
- done  out  1  high in DONE.
- correct  out  1  in DONE, high iff err_count==0.
- err_count  out  7  cells with puzzle != solution, including blanks.
- blank_count  out  7  cells with puzzle value 0.
- first_err_row, first_err_col  out  4 each  first mismatching cell in scan order; 4'hF if none.
- q_Idle, q_Scan, q_Drain, q_Done  out  1 each  one-hot state.

Function
REQ-002 The state machine SHALL be one-hot with states IDLE, SCAN, DRAIN, DONE.
REQ-003 IDLE, Start=1: go to SCAN; clear scan row/col, err_count, blank_count; set first_err_row/col to 4'hF.
REQ-004 In IDLE with Start=0, all counters and results SHALL hold.
REQ-005 Display has fixed priority in every state: disp_req=1 -> mem_addr=disp_addr, scan not issued.
REQ-006 disp_valid SHALL be disp_req registered by one cycle; compare logic ignores data when disp_valid=1.
REQ-007 SCAN, disp_req=0: mem_addr=row*9+col; issue tag (valid,row,col) registered for the return cycle; advance col, col 8 wraps to 0 and row+1.
REQ-008 SCAN, disp_req=1: row/col SHALL hold; issue tag valid=0 (stall, no cycle lost or duplicated).
REQ-009 Issuing cell (8,8) SHALL move SCAN -> DRAIN next cycle; no address beyond 80 is ever issued.
REQ-010 On each cycle with registered tag valid=1: puzzle_q!=solu_q -> err_count+1; puzzle_q==0 -> blank_count+1; first mismatch only -> first_err_row/col=tag row/col.
REQ-011 DRAIN SHALL last exactly one cycle, consuming the (8,8) return, then go to DONE.
REQ-012 Each of the 81 cells SHALL be compared exactly once per check regardless of display stalls.
REQ-013 Scan latency with no display traffic SHALL be 83 cycles from Start sample to done=1 (81 SCAN, 1 DRAIN, then DONE).
REQ-014 In DONE, results SHALL hold stable, correct=(err_count==0).
REQ-015 DONE, Ack=1: go to IDLE, results retained until next Start.
REQ-016 Start outside IDLE and Ack outside DONE SHALL be ignored.
REQ-017 When not in SCAN and disp_req=0, mem_addr SHALL be 0.
REQ-018 Counters are 7 bits; maximum 81, no saturation logic needed.

Reset
REQ-019 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-scan.
REQ-020 Reset SHALL clear err_count, blank_count, scan row/col, issue tag and disp_valid to 0.
REQ-021 Reset SHALL set first_err_row/col to 4'hF; done, busy and correct go to 0.
REQ-022 Reset SHALL take priority over Start and Ack in the same cycle.

Verification
REQ-023 Matching board, Start one cycle, no disp_req -> done at cycle 83; correct=1, err_count=0, first_err=F/F.
REQ-024 Board with 3 blanks, blanks at (0,0),(4,4),(8,8) -> err_count=3, blank_count=3, first_err=(0,0), correct=0.
REQ-025 Single wrong non-zero value at (5,7), disp_req high every other cycle -> done at cycle 83+stall count; err_count=1, blank_count=0, first_err=(5,7); no cell double-counted.
REQ-026 Start while disp_req held high 10 cycles -> row/col frozen, mem_addr=disp_addr, disp_valid one cycle later; scan resumes at (0,0).
REQ-027 Reset asserted mid-scan at cell (3,2) -> next cycle q_Idle=1, counts 0, first_err=F/F; new Start performs a full 81-cell check.
REQ-028 Start asserted in DONE and Ack asserted in SCAN -> both ignored; Ack in DONE -> IDLE with results held.
